// File: rtl/coletor_pkg.sv
// coletor_pkg: shared definitions for the 4-phase bus slot collector.
//   NSLOTS    - number of time-multiplexed phases / slots
//   IDX_W     - width of an encoded phase index
//   state_t   - collector FSM states
//   is_onehot - true when exactly one strobe bit is set
package coletor_pkg;

    localparam int unsigned NSLOTS = 4;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic {
        SYNC    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    function automatic logic is_onehot(input logic [NSLOTS-1:0] v);
        return $countones(v) == 1;
    endfunction

endpackage

// File: rtl/coletor_slots_if.sv
// coletor_slots_if: multiplexed bus input and published-frame outputs.
//   sel, din                      - phase strobes and shared data (bus side drives)
//   dout, frame_valid, seq_err,
//   onehot_err, stall             - collector results (collector drives)
// Modports: master = bus/consumer side, slave = collector.
interface coletor_slots_if #(
    parameter int unsigned DATA_W = 4
);
    import coletor_pkg::*;

    logic [NSLOTS-1:0]        sel;
    logic [DATA_W-1:0]        din;
    logic [NSLOTS*DATA_W-1:0] dout;
    logic                     frame_valid;
    logic                     seq_err;
    logic                     onehot_err;
    logic                     stall;

    modport master (
        output sel, din,
        input  dout, frame_valid, seq_err, onehot_err, stall
    );

    modport slave (
        input  sel, din,
        output dout, frame_valid, seq_err, onehot_err, stall
    );

endinterface

// File: rtl/codificador_onehot.sv
// codificador_onehot: combinational 4-to-2 encoder for the phase strobes.
//   sel   in  NSLOTS  strobes
//   idx   out IDX_W   index of the set bit (meaningful only when valid)
//   valid out 1       sel is exactly one-hot
module codificador_onehot
    import coletor_pkg::*;
(
    input  logic [NSLOTS-1:0] sel,
    output logic [IDX_W-1:0]  idx,
    output logic              valid
);

    // Priority scan; for illegal inputs idx is a don't-care.
    always_comb begin
        idx   = '0;
        valid = is_onehot(sel);
        for (int unsigned i = 0; i < NSLOTS; i++) begin
            if (sel[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/coletor_slots.sv
// coletor_slots: collects one data word per bus phase into slot registers and
// publishes a coherent 4-slot frame once phases 0..3 arrive in order.
//   CLK, RST_n  - clock, asynchronous active-low reset
//   bus.sel     - one-hot phase strobes; bus.din - shared data word
//   bus.dout    - published frame, slot k at [k*DATA_W +: DATA_W]
//   bus.frame_valid / seq_err / onehot_err - one-cycle registered pulses
//   bus.stall   - level, no phase entry for TIMEOUT cycles
module coletor_slots
    import coletor_pkg::*;
#(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic           CLK,
    input  logic           RST_n,
    coletor_slots_if.slave bus
);

    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned FRM_W  = NSLOTS * DATA_W;

    logic [IDX_W-1:0] idx;
    logic             sel_legal;

    codificador_onehot u_enc (
        .sel   (bus.sel),
        .idx   (idx),
        .valid (sel_legal)
    );

    state_t                           state_q, state_d;
    logic [IDX_W-1:0]                 exp_q, exp_d;
    logic [NSLOTS-2:0][DATA_W-1:0]    shadow_q, shadow_d;
    logic [FRM_W-1:0]                 dout_q, dout_d;
    logic [NSLOTS-1:0]                sel_q;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             fv_q, fv_d;
    logic                             seq_q, seq_d;
    logic                             oh_q, oh_d;
    logic                             stall_q, stall_d;
    logic                             changed;
    logic                             entry;

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q  <= SYNC;
            exp_q    <= '0;
            shadow_q <= '0;
            dout_q   <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            fv_q     <= 1'b0;
            seq_q    <= 1'b0;
            oh_q     <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            shadow_q <= shadow_d;
            dout_q   <= dout_d;
            sel_q    <= bus.sel;
            cnt_q    <= cnt_d;
            fv_q     <= fv_d;
            seq_q    <= seq_d;
            oh_q     <= oh_d;
            stall_q  <= stall_d;
        end
    end

    // Next-state, capture and flag logic.
    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        shadow_d = shadow_q;
        dout_d   = dout_q;
        fv_d     = 1'b0;
        seq_d    = 1'b0;
        oh_d     = 1'b0;

        // A strobe held across cycles is a single entry.
        changed = (bus.sel != sel_q);
        entry   = sel_legal && changed;

        if (entry) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        stall_d = (cnt_d == CNT_W'(TIMEOUT));

        if (!sel_legal) begin
            // Flag only when the illegal value appears, so an idle bus
            // parked at zero reports once rather than every cycle.
            oh_d    = changed;
            state_d = SYNC;
        end else if (entry) begin
            unique case (state_q)
                SYNC: begin
                    if (idx == '0) begin
                        shadow_d[0] = bus.din;
                        exp_d       = IDX_W'(1);
                        state_d     = COLLECT;
                    end
                end
                COLLECT: begin
                    if (idx == exp_q) begin
                        if (idx == IDX_W'(NSLOTS - 1)) begin
                            // Last phase goes straight into the frame.
                            dout_d  = {bus.din, shadow_q};
                            fv_d    = 1'b1;
                            state_d = SYNC;
                        end else begin
                            shadow_d[idx] = bus.din;
                            exp_d         = exp_q + IDX_W'(1);
                        end
                    end else begin
                        seq_d = 1'b1;
                        if (idx == '0) begin
                            shadow_d[0] = bus.din;
                            exp_d       = IDX_W'(1);
                        end else begin
                            state_d = SYNC;
                        end
                    end
                end
                default: state_d = SYNC;
            endcase
        end else if (stall_d) begin
            state_d = SYNC;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.frame_valid = fv_q;
    assign bus.seq_err     = seq_q;
    assign bus.onehot_err  = oh_q;
    assign bus.stall       = stall_q;

endmodule

// File: tb/tb_coletor_slots.sv
module tb_coletor_slots;

    localparam int unsigned DATA_W  = 4;
    localparam int unsigned TIMEOUT = 16;

    typedef struct {
        int unsigned cyc;
        logic        fv;
        logic        seq;
        logic        oh;
        logic        stall;
        logic [15:0] dout;
    } exp_t;

    logic CLK;
    logic RST_n;
    int unsigned cyc = 0;
    int checks = 0;
    int failures = 0;

    exp_t sb[$];

    // Reference model state: frame being assembled, last strobe, idle cycles.
    logic [3:0]  m_part[$];
    logic [3:0]  m_prev;
    int          m_idle;
    logic [15:0] m_dout;

    coletor_slots_if #(.DATA_W(DATA_W)) bus ();

    coletor_slots #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    // Monitor: compare the DUT against the expectation due this cycle.
    always @(negedge CLK) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("frame_valid", 16'(bus.frame_valid), 16'(e.fv));
            chk("seq_err",     16'(bus.seq_err),     16'(e.seq));
            chk("onehot_err",  16'(bus.onehot_err),  16'(e.oh));
            chk("stall",       16'(bus.stall),       16'(e.stall));
            chk("dout",        bus.dout,             e.dout);
        end
    end

    task automatic model_reset();
        m_part.delete();
        m_prev = 4'd0;
        m_idle = 0;
        m_dout = 16'h0;
    endtask

    // Frame rules stated on a list of collected words: a frame is the list
    // of phases 0,1,2,3 arriving in order; anything else breaks it.
    task automatic model_step(input logic [3:0] s, input logic [3:0] d, output exp_t e);
        bit legal;
        bit changed;
        bit entry;
        int k;
        legal   = ($countones(s) == 1);
        changed = (s != m_prev);
        entry   = legal && changed;
        e.fv  = 1'b0;
        e.seq = 1'b0;
        e.oh  = !legal && changed;
        if (entry) m_idle = 0;
        else if (m_idle < TIMEOUT) m_idle++;
        e.stall = (m_idle == TIMEOUT);
        k = 0;
        for (int i = 0; i < 4; i++) if (s[i]) k = i;
        if (!legal) begin
            m_part.delete();
        end else if (entry) begin
            if (m_part.size() == 0) begin
                if (k == 0) m_part.push_back(d);
            end else if (k == m_part.size()) begin
                m_part.push_back(d);
                if (m_part.size() == 4) begin
                    m_dout = {m_part[3], m_part[2], m_part[1], m_part[0]};
                    e.fv = 1'b1;
                    m_part.delete();
                end
            end else begin
                e.seq = 1'b1;
                m_part.delete();
                if (k == 0) m_part.push_back(d);
            end
        end else if (e.stall) begin
            m_part.delete();
        end
        m_prev = s;
        e.dout = m_dout;
    endtask

    task automatic drive(input logic [3:0] s, input logic [3:0] d);
        exp_t e;
        bus.sel = s;
        bus.din = d;
        model_step(s, d, e);
        e.cyc = cyc + 1;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dout"},        bus.dout,              16'h0);
        chk({tag, "_frame_valid"}, 16'(bus.frame_valid),  16'h0);
        chk({tag, "_seq_err"},     16'(bus.seq_err),      16'h0);
        chk({tag, "_onehot_err"},  16'(bus.onehot_err),   16'h0);
        chk({tag, "_stall"},       16'(bus.stall),        16'h0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK);
        #1;
        RST_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        bus.sel = 4'd0;
        bus.din = 4'd0;
        RST_n = 1'b1;
    endtask

    initial begin
        logic [3:0] frame_d[4];
        logic [3:0] s;
        logic [3:0] bad[5];
        int ph;
        int r;

        RST_n   = 1'b1;
        bus.sel = 4'd0;
        bus.din = 4'd0;
        model_reset();
        #3 RST_n = 1'b0;
        #2;
        check_reset_outputs("por");
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST_n = 1'b1;

        // Clean full-rate frame: expect 16'h9173.
        frame_d[0] = 4'd3; frame_d[1] = 4'd7; frame_d[2] = 4'd1; frame_d[3] = 4'd9;
        for (int i = 0; i < 4; i++) drive(4'(1 << i), frame_d[i]);
        drive(4'd8, 4'd0);

        // Each strobe held three cycles.
        for (int i = 0; i < 4; i++) repeat (3) drive(4'(1 << i), frame_d[i]);

        // Skipped phase, then a clean frame.
        drive(4'd1, 4'd5); drive(4'd2, 4'd6); drive(4'd8, 4'd2);
        drive(4'd1, 4'd4); drive(4'd2, 4'd8); drive(4'd4, 4'd2); drive(4'd8, 4'd6);

        // Illegal strobe mid-frame, then a fresh frame.
        drive(4'd1, 4'd1); drive(4'd2, 4'd2); drive(4'b0110, 4'd3);
        drive(4'd4, 4'd3); drive(4'd8, 4'd4);
        drive(4'd1, 4'hA); drive(4'd2, 4'hB); drive(4'd4, 4'hC); drive(4'd8, 4'hD);

        // Idle bus at zero until stall, then recovery.
        repeat (20) drive(4'd0, 4'd0);
        drive(4'd1, 4'd2); drive(4'd2, 4'd3); drive(4'd4, 4'd4); drive(4'd8, 4'd5);

        // Stall while a legal strobe is held in the middle of a frame.
        drive(4'd1, 4'd7);
        repeat (18) drive(4'd1, 4'd7);
        drive(4'd2, 4'd1); drive(4'd4, 4'd1); drive(4'd8, 4'd1);

        // Reset after phases 0 and 1; a frame starting at phase 2 is ignored.
        drive(4'd1, 4'd9); drive(4'd2, 4'd8);
        do_reset("midrst");
        drive(4'd4, 4'd1); drive(4'd8, 4'd2);
        drive(4'd1, 4'd6); drive(4'd2, 4'd5); drive(4'd4, 4'd4); drive(4'd8, 4'd3);

        // Randomised traffic.
        bad[0] = 4'd0; bad[1] = 4'd3; bad[2] = 4'd6; bad[3] = 4'hF; bad[4] = 4'd9;
        ph = 3;
        s  = 4'd8;
        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60) begin
                ph = (ph + 1) % 4;
                s  = 4'(1 << ph);
                drive(s, 4'($urandom_range(0, 15)));
            end else if (r < 75) begin
                drive(s, 4'($urandom_range(0, 15)));
            end else if (r < 88) begin
                ph = int'($urandom_range(0, 3));
                s  = 4'(1 << ph);
                drive(s, 4'($urandom_range(0, 15)));
            end else if (r < 97) begin
                s = bad[$urandom_range(0, 4)];
                drive(s, 4'($urandom_range(0, 15)));
            end else begin
                s = 4'd0;
                repeat ($urandom_range(1, 20)) drive(s, 4'd0);
            end
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge CLK);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
